// File: rtl/status_bus_master.sv
// Status register bus master: forwards single-beat JTAG Avalon-MM accesses onto the shared
// status bus, collects slave read returns and keeps local bus-health counters.
module status_bus_master #(
    parameter int unsigned          NUM_SLAVES = 8,
    parameter int unsigned          SEL_WIDTH  = 4,
    parameter logic [SEL_WIDTH-1:0] LOCAL_SEL  = '1,
    parameter int unsigned          TIMEOUT    = 64
) (
    input  logic                       clk_status,
    input  logic                       rst,
    input  logic [29:0]                jtag_address,
    input  logic                       jtag_read,
    input  logic                       jtag_write,
    input  logic [31:0]                jtag_writedata,
    output logic                       jtag_waitrequest,
    output logic [31:0]                jtag_readdata,
    output logic                       jtag_readdatavalid,
    output logic [29:0]                status_addr,
    output logic                       status_read,
    output logic                       status_write,
    output logic [31:0]                status_writedata,
    input  logic [32*NUM_SLAVES-1:0]   status_readdata,
    input  logic [NUM_SLAVES-1:0]      status_readdata_valid
);

    localparam int unsigned    TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]    ERR_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdWait,
        StRdLocal,
        StResp
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    local_off;
    logic [31:0]   read_cnt;
    logic [31:0]   timeout_cnt;
    logic [31:0]   multi_cnt;
    logic [31:0]   stray_cnt;

    logic          any_valid;
    logic          multi_valid;
    logic          stray;
    logic          is_local;
    logic          is_clear;
    logic          accept_rd;
    logic          accept_wr;
    logic [31:0]   first_data;
    logic [31:0]   local_data;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Scanning downwards leaves the lowest-index valid slave's data in place.
    always_comb begin
        first_data = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (status_readdata_valid[i]) begin
                first_data = status_readdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        local_data = ERR_DATA;
        case (local_off)
            4'd0:    local_data = read_cnt;
            4'd1:    local_data = timeout_cnt;
            4'd2:    local_data = multi_cnt;
            4'd3:    local_data = stray_cnt;
            default: local_data = ERR_DATA;
        endcase
    end

    assign any_valid   = |status_readdata_valid;
    assign multi_valid = |(status_readdata_valid & (status_readdata_valid - NUM_SLAVES'(1)));
    assign stray       = any_valid && (state != StRdWait);
    assign is_local    = (jtag_address[29 -: SEL_WIDTH] == LOCAL_SEL);
    assign is_clear    = is_local && (jtag_address[3:0] == 4'hF);
    // Read has priority; a simultaneous write stays presented under waitrequest.
    assign accept_rd   = (state == StIdle) && !jtag_waitrequest && jtag_read;
    assign accept_wr   = (state == StIdle) && !jtag_waitrequest && !jtag_read && jtag_write;

    always_ff @(posedge clk_status) begin
        if (rst) begin
            state              <= StIdle;
            timer              <= '0;
            local_off          <= '0;
            jtag_waitrequest   <= 1'b1;
            jtag_readdata      <= '0;
            jtag_readdatavalid <= 1'b0;
            status_addr        <= '0;
            status_read        <= 1'b0;
            status_write       <= 1'b0;
            status_writedata   <= '0;
            read_cnt           <= '0;
            timeout_cnt        <= '0;
            multi_cnt          <= '0;
            stray_cnt          <= '0;
        end else begin
            status_read        <= 1'b0;
            status_write       <= 1'b0;
            jtag_readdatavalid <= 1'b0;

            if (stray) begin
                stray_cnt <= sat_inc(stray_cnt);
            end

            case (state)
                StIdle: begin
                    if (accept_rd) begin
                        jtag_waitrequest <= 1'b1;
                        if (is_local) begin
                            local_off <= jtag_address[3:0];
                            state     <= StRdLocal;
                        end else begin
                            status_addr <= jtag_address;
                            status_read <= 1'b1;
                            timer       <= '0;
                            state       <= StRdWait;
                        end
                    end else if (accept_wr) begin
                        jtag_waitrequest <= 1'b1;
                        status_addr      <= jtag_address;
                        status_writedata <= jtag_writedata;
                        status_write     <= 1'b1;
                        state            <= StWr;
                        // Clear overrides any stray increment in the same cycle.
                        if (is_clear) begin
                            read_cnt    <= '0;
                            timeout_cnt <= '0;
                            multi_cnt   <= '0;
                            stray_cnt   <= '0;
                        end
                    end else begin
                        jtag_waitrequest <= 1'b0;
                    end
                end

                StWr: begin
                    jtag_waitrequest <= 1'b0;
                    state            <= StIdle;
                end

                StRdWait: begin
                    if (any_valid) begin
                        jtag_readdata      <= first_data;
                        jtag_readdatavalid <= 1'b1;
                        read_cnt           <= sat_inc(read_cnt);
                        if (multi_valid) begin
                            multi_cnt <= sat_inc(multi_cnt);
                        end
                        state <= StResp;
                    end else if (timer == TIMER_LAST) begin
                        jtag_readdata      <= ERR_DATA;
                        jtag_readdatavalid <= 1'b1;
                        timeout_cnt        <= sat_inc(timeout_cnt);
                        state              <= StResp;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                StRdLocal: begin
                    jtag_readdata      <= local_data;
                    jtag_readdatavalid <= 1'b1;
                    state              <= StResp;
                end

                StResp: begin
                    jtag_waitrequest <= 1'b0;
                    state            <= StIdle;
                end

                default: begin
                    jtag_waitrequest <= 1'b1;
                    state            <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_bus_master.sv
// Bench for status_bus_master: directed scenarios plus randomized traffic, all checked every
// cycle against a transaction-level model built from cycle-window arithmetic.
module tb_status_bus_master;

    localparam int NS = 8;
    localparam int TO = 64;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic              clk_status = 1'b0;
    logic              rst;
    logic [29:0]       jtag_address;
    logic              jtag_read;
    logic              jtag_write;
    logic [31:0]       jtag_writedata;
    logic              jtag_waitrequest;
    logic [31:0]       jtag_readdata;
    logic              jtag_readdatavalid;
    logic [29:0]       status_addr;
    logic              status_read;
    logic              status_write;
    logic [31:0]       status_writedata;
    logic [32*NS-1:0]  status_readdata;
    logic [NS-1:0]     status_readdata_valid;

    always #5 clk_status = ~clk_status;

    status_bus_master #(
        .NUM_SLAVES (NS),
        .SEL_WIDTH  (4),
        .LOCAL_SEL  (4'hF),
        .TIMEOUT    (TO)
    ) dut (
        .clk_status            (clk_status),
        .rst                   (rst),
        .jtag_address          (jtag_address),
        .jtag_read             (jtag_read),
        .jtag_write            (jtag_write),
        .jtag_writedata        (jtag_writedata),
        .jtag_waitrequest      (jtag_waitrequest),
        .jtag_readdata         (jtag_readdata),
        .jtag_readdatavalid    (jtag_readdatavalid),
        .status_addr           (status_addr),
        .status_read           (status_read),
        .status_write          (status_write),
        .status_writedata      (status_writedata),
        .status_readdata       (status_readdata),
        .status_readdata_valid (status_readdata_valid)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic logic [29:0] mk_addr(input logic [3:0] sel, input logic [3:0] off);
        return {sel, 22'h0, off};
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---------------- reference model ----------------
    bit          model_valid = 0;
    int          ready_at;
    bit          rd_open;
    int          rd_first;
    int          rd_last;
    bit          local_pend;
    int          local_at;
    logic [3:0]  local_off_m;
    logic [31:0] m_cnt [4];
    logic [31:0] m_nxt [4];
    logic        exp_wait;
    logic        exp_rdv;
    logic        exp_sread;
    logic        exp_swrite;
    logic [31:0] exp_rdata;
    logic [31:0] exp_swdata;
    logic [29:0] exp_saddr;

    always @(posedge clk_status) begin : model_blk
        bit in_win;
        int lo;
        int pc;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = '0;
            exp_wait    = 1'b1;
            exp_rdv     = 1'b0;
            exp_rdata   = '0;
            exp_sread   = 1'b0;
            exp_swrite  = 1'b0;
            exp_saddr   = '0;
            exp_swdata  = '0;
            ready_at    = cyc + 2;
            rd_open     = 0;
            local_pend  = 0;
            model_valid = 1;
        end else if (model_valid) begin
            for (int k = 0; k < 4; k++) m_nxt[k] = m_cnt[k];
            in_win     = rd_open && (cyc >= rd_first) && (cyc <= rd_last);
            exp_sread  = 1'b0;
            exp_swrite = 1'b0;
            exp_rdv    = 1'b0;
            lo = -1;
            pc = 0;
            for (int k = NS - 1; k >= 0; k--) begin
                if (status_readdata_valid[k]) begin
                    lo = k;
                    pc++;
                end
            end
            if (pc > 0 && !in_win) m_nxt[3] = sat(m_nxt[3]);
            if (in_win && pc > 0) begin
                exp_rdv   = 1'b1;
                exp_rdata = status_readdata[32*lo +: 32];
                m_nxt[0]  = sat(m_nxt[0]);
                if (pc > 1) m_nxt[2] = sat(m_nxt[2]);
                rd_open   = 0;
                ready_at  = cyc + 2;
            end else if (in_win && cyc == rd_last) begin
                exp_rdv   = 1'b1;
                exp_rdata = ERR;
                m_nxt[1]  = sat(m_nxt[1]);
                rd_open   = 0;
                ready_at  = cyc + 2;
            end
            if (local_pend && cyc == local_at) begin
                exp_rdv    = 1'b1;
                exp_rdata  = (local_off_m < 4) ? m_cnt[local_off_m[1:0]] : ERR;
                local_pend = 0;
            end
            if (!exp_wait && (jtag_read || jtag_write)) begin
                if (jtag_read) begin
                    if (jtag_address[29:26] == 4'hF) begin
                        local_pend  = 1;
                        local_at    = cyc + 1;
                        local_off_m = jtag_address[3:0];
                        ready_at    = cyc + 3;
                    end else begin
                        exp_sread = 1'b1;
                        exp_saddr = jtag_address;
                        rd_open   = 1;
                        rd_first  = cyc + 1;
                        rd_last   = cyc + TO;
                        ready_at  = 32'h7FFF_FFFF;
                    end
                end else begin
                    exp_swrite = 1'b1;
                    exp_saddr  = jtag_address;
                    exp_swdata = jtag_writedata;
                    ready_at   = cyc + 2;
                    if (jtag_address[29:26] == 4'hF && jtag_address[3:0] == 4'hF) begin
                        for (int k = 0; k < 4; k++) m_nxt[k] = '0;
                    end
                end
            end
            for (int k = 0; k < 4; k++) m_cnt[k] = m_nxt[k];
            exp_wait = (cyc + 1 < ready_at);
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_status) begin
        if (model_valid) begin
            chk("waitrequest", jtag_waitrequest, exp_wait);
            chk("readdatavalid", jtag_readdatavalid, exp_rdv);
            if (exp_rdv) chk("readdata", jtag_readdata, exp_rdata);
            chk("status_read", status_read, exp_sread);
            chk("status_write", status_write, exp_swrite);
            if (exp_sread || exp_swrite) chk("status_addr", status_addr, exp_saddr);
            if (exp_swrite) chk("status_writedata", status_writedata, exp_swdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_slot(input int i, input logic [31:0] d);
        status_readdata[32*i +: 32] = d;
    endtask

    task automatic idle_until(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clk_status);
    endtask

    task automatic do_read(input logic [29:0] a, output int t);
        jtag_address = a;
        jtag_read    = 1'b1;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            if (!jtag_waitrequest) begin
                t = cyc;
                break;
            end
            @(negedge clk_status);
        end
        chk("rd_accepted", t >= 0, 1);
        @(negedge clk_status);
        jtag_read = 1'b0;
    endtask

    task automatic do_write(input logic [29:0] a, input logic [31:0] d, output int t);
        jtag_address   = a;
        jtag_writedata = d;
        jtag_write     = 1'b1;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            if (!jtag_waitrequest) begin
                t = cyc;
                break;
            end
            @(negedge clk_status);
        end
        chk("wr_accepted", t >= 0, 1);
        @(negedge clk_status);
        jtag_write = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int t, output logic [31:0] d);
        bit found;
        found = 0;
        t = -1;
        d = '0;
        for (int i = 0; i < limit; i++) begin
            if (jtag_readdatavalid) begin
                t = cyc;
                d = jtag_readdata;
                found = 1;
                break;
            end
            @(negedge clk_status);
        end
        chk("resp_seen", found, 1);
    endtask

    task automatic local_read(input logic [3:0] off, input logic [31:0] expd, input string nm);
        int t;
        int rt;
        logic [31:0] d;
        do_read(mk_addr(4'hF, off), t);
        wait_resp(20, rt, d);
        chk({nm, "_latency"}, rt - t, 2);
        chk(nm, d, expd);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int rt;
        int rc;
        int wc;
        int acc_w;
        int n;
        int vprob;
        bit req;
        bit acc;
        int r;
        logic [3:0] sel;
        logic [31:0] d;
        logic [31:0] rdat;

        rst = 1'b1;
        jtag_address = '0;
        jtag_read = 1'b0;
        jtag_write = 1'b0;
        jtag_writedata = '0;
        status_readdata = '0;
        status_readdata_valid = '0;
        repeat (3) @(negedge clk_status);

        chk("reset_waitrequest", jtag_waitrequest, 1);
        chk("reset_readdatavalid", jtag_readdatavalid, 0);
        chk("reset_readdata", jtag_readdata, 0);
        chk("reset_status_read", status_read, 0);
        chk("reset_status_write", status_write, 0);
        chk("reset_status_addr", status_addr, 0);
        chk("reset_status_writedata", status_writedata, 0);
        rst = 1'b0;

        // Slave 0 answers two cycles after the pulse.
        do_read(mk_addr(4'h0, 4'h1), t);
        idle_until(t + 3);
        set_slot(0, 32'h0000_0042);
        status_readdata_valid = 8'h01;
        @(negedge clk_status);
        status_readdata_valid = '0;
        wait_resp(200, rt, d);
        chk("read_latency", rt - t, 4);
        chk("read_data", d, 32'h42);
        local_read(4'h0, 32'd1, "read_cnt_1");

        // Nobody answers: timeout response, then a late valid counts as stray.
        do_read(mk_addr(4'h1, 4'h0), t);
        wait_resp(100, rt, d);
        chk("timeout_latency", rt - t, 65);
        chk("timeout_data", d, ERR);
        idle_until(t + 70);
        set_slot(3, 32'h3333_3333);
        status_readdata_valid = 8'h08;
        @(negedge clk_status);
        status_readdata_valid = '0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (jtag_readdatavalid) n++;
            @(negedge clk_status);
        end
        chk("no_second_response", n, 0);
        local_read(4'h1, 32'd1, "timeout_cnt_1");
        local_read(4'h3, 32'd1, "stray_cnt_1");

        // Slaves 2 and 5 collide: lowest index wins.
        do_read(mk_addr(4'h2, 4'h4), t);
        idle_until(t + 2);
        set_slot(2, 32'h2);
        set_slot(5, 32'h5);
        status_readdata_valid = 8'h24;
        @(negedge clk_status);
        status_readdata_valid = '0;
        wait_resp(100, rt, d);
        chk("multi_latency", rt - t, 3);
        chk("multi_data", d, 32'h2);
        local_read(4'h2, 32'd1, "multi_cnt_1");
        local_read(4'h0, 32'd2, "read_cnt_2");

        // Plain write, then a counter-clearing local write.
        do_write(mk_addr(4'h3, 4'h2), 32'h0000_CAFE, t);
        chk("wr_pulse", status_write, 1);
        chk("wr_addr", status_addr, mk_addr(4'h3, 4'h2));
        chk("wr_data", status_writedata, 32'h0000_CAFE);
        chk("wr_wait_high", jtag_waitrequest, 1);
        chk("wr_no_resp", jtag_readdatavalid, 0);
        @(negedge clk_status);
        chk("wr_pulse_end", status_write, 0);
        chk("wr_wait_low", jtag_waitrequest, 0);
        do_write(mk_addr(4'hF, 4'hF), 32'h0, t);
        local_read(4'h0, 32'd0, "cleared_read_cnt");
        local_read(4'h1, 32'd0, "cleared_timeout_cnt");
        local_read(4'h2, 32'd0, "cleared_multi_cnt");
        local_read(4'h3, 32'd0, "cleared_stray_cnt");
        local_read(4'h5, ERR, "local_bad_offset");

        // Read and write presented together.
        jtag_address = mk_addr(4'h0, 4'h9);
        jtag_writedata = 32'h5555_AAAA;
        jtag_read = 1'b1;
        jtag_write = 1'b1;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            if (!jtag_waitrequest) begin
                t = cyc;
                break;
            end
            @(negedge clk_status);
        end
        @(negedge clk_status);
        jtag_read = 1'b0;
        rc = -1;
        wc = -1;
        acc_w = -1;
        rdat = '0;
        set_slot(1, 32'h1111);
        for (int i = 0; i < 40; i++) begin
            status_readdata_valid = (cyc == t + 2) ? 8'h02 : 8'h00;
            if (jtag_readdatavalid && rc < 0) begin
                rc = cyc;
                rdat = jtag_readdata;
            end
            if (status_write && wc < 0) wc = cyc;
            if (acc_w < 0 && jtag_write && !jtag_waitrequest) acc_w = cyc;
            else if (acc_w >= 0) jtag_write = 1'b0;
            @(negedge clk_status);
        end
        status_readdata_valid = '0;
        jtag_write = 1'b0;
        chk("rw_read_latency", rc - t, 3);
        chk("rw_read_data", rdat, 32'h1111);
        chk("rw_write_after_resp", wc - rc, 2);

        // Reset while waiting for a slave.
        do_read(mk_addr(4'h0, 4'h7), t);
        idle_until(t + 5);
        rst = 1'b1;
        @(negedge clk_status);
        chk("rst_wait_a", jtag_waitrequest, 1);
        @(negedge clk_status);
        chk("rst_wait_b", jtag_waitrequest, 1);
        rst = 1'b0;
        @(negedge clk_status);
        set_slot(0, 32'h77);
        status_readdata_valid = 8'h01;
        @(negedge clk_status);
        status_readdata_valid = '0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (jtag_readdatavalid) n++;
            @(negedge clk_status);
        end
        chk("no_resp_after_rst", n, 0);
        local_read(4'h3, 32'd1, "stray_after_rst");
        local_read(4'h0, 32'd0, "read_cnt_after_rst");

        // Randomized traffic.
        req = 0;
        acc = 0;
        vprob = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) vprob = ($urandom_range(0, 1) == 1) ? 4 : 80;
            if (acc) begin
                jtag_read = 1'b0;
                jtag_write = 1'b0;
                req = 0;
                acc = 0;
            end
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                jtag_read = 1'b0;
                jtag_write = 1'b0;
                req = 0;
            end else begin
                if (!req && $urandom_range(0, 2) == 0) begin
                    sel = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
                    jtag_address = {sel, 22'($urandom), 4'($urandom_range(0, 15))};
                    jtag_writedata = $urandom;
                    r = $urandom_range(0, 3);
                    jtag_read = (r != 0);
                    jtag_write = (r == 0) || (r == 3);
                    req = 1;
                end
                if (req && !jtag_waitrequest) acc = 1;
            end
            for (int k = 0; k < NS; k++) set_slot(k, $urandom);
            status_readdata_valid = ($urandom_range(0, vprob - 1) == 0) ? 8'($urandom) : 8'h00;
            @(negedge clk_status);
        end
        rst = 1'b0;
        jtag_read = 1'b0;
        jtag_write = 1'b0;
        status_readdata_valid = '0;
        repeat (100) @(negedge clk_status);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/status_bus_master.md
Name: status_bus_master

Overview:
- Bridges the JTAG-to-Avalon-MM master onto the shared status register bus that every datapath block decodes, including the DRAM wrapper and the FIFO/arbiter stages.
- Accepts single-beat reads and writes on the clk_status domain and broadcasts registered address, read, write and writedata to all slaves.
- Collects the per-slave readdata/readdata_valid returns and hands one read response back to the JTAG master.
- Guarantees forward progress with a response timeout and keeps its own bus-health counters at a local address select.

Parameters:
- NUM_SLAVES, 8, number of status slaves with readdata/valid return lanes.
- SEL_WIDTH, 4, width of the address select field (bits [29:30-SEL_WIDTH]); matches STAT_AWIDTH.
- LOCAL_SEL, 4'hF, select value decoded internally; never broadcast as a read.
- TIMEOUT, 64, number of WAIT cycles before a read completes with error data; must be at least 4.

Ports:
- clk_status  in  1  status bus clock.
- rst  in  1  reset, synchronous, active-high.
- jtag_address  in  30  word address from the JTAG master.
- jtag_read  in  1  read request.
- jtag_write  in  1  write request.
- jtag_writedata  in  32  write data.
- jtag_waitrequest  out  1  1 = request not accepted this cycle.
- jtag_readdata  out  32  read response data.
- jtag_readdatavalid  out  1  one-cycle response strobe.
- status_addr  out  30  broadcast address to slaves.
- status_read  out  1  broadcast read pulse.
- status_write  out  1  broadcast write pulse.
- status_writedata  out  32  broadcast write data.
- status_readdata  in  32*NUM_SLAVES  slave i return data in bits [32i+31:32i].
- status_readdata_valid  in  NUM_SLAVES  slave i return strobe.

Behaviour:
- Reset values:
  - jtag_waitrequest=1, jtag_readdatavalid=0, jtag_readdata=0.
  - status_read=0, status_write=0, status_addr=0, status_writedata=0.
  - All counters 0; state IDLE.
- Registers are cleared on the cycle rst is sampled. Reset mid-transaction returns to IDLE and emits no response.
- jtag_waitrequest=0 only in IDLE. A request is accepted when it is present in IDLE.
- If jtag_read and jtag_write are both high, the read wins. The write is not lost: it stays presented under waitrequest.
- FSM states: IDLE, WR, RD_WAIT, RD_LOCAL, RESP.
- IDLE, read accepted at cycle T, select != LOCAL_SEL:
  - status_addr=jtag_address and status_read=1 for exactly cycle T+1.
  - Enter RD_WAIT; timer=0 at T+1, incrementing each cycle in RD_WAIT.
- IDLE, read accepted at T, select == LOCAL_SEL:
  - No status_read pulse; enter RD_LOCAL.
  - Response at T+2 with the local register selected by address[3:0]:
    - 0 = read_cnt, 1 = timeout_cnt, 2 = multi_cnt, 3 = stray_cnt.
    - Any other offset returns 32'hDEADBEEF.
- IDLE, write accepted at T:
  - status_addr, status_writedata and status_write=1 for cycle T+1 only; enter WR, then IDLE at T+2.
  - Writes are broadcast even when the select is LOCAL_SEL.
  - A write to LOCAL_SEL offset 4'hF additionally clears all four counters at T+1.
  - Writes produce no response.
- RD_WAIT response handling:
  - On the first cycle with any status_readdata_valid bit set, capture the data of the lowest-index valid slave.
  - Enter RESP; jtag_readdatavalid=1 with that data on the following cycle.
  - read_cnt increments (saturating) on that response.
- RD_WAIT, more than one valid bit in the same cycle: lowest index wins and multi_cnt increments by 1.
- RD_WAIT timeout: if timer reaches TIMEOUT-1 with no valid, the response is 32'hDEADBEEF and timeout_cnt increments. A valid in that same cycle wins over the timeout.
- RESP lasts one cycle, then IDLE. Minimum read turnaround for a slave answering 2 cycles after the pulse: accept T, pulse T+1, valid T+3, jtag_readdatavalid T+4.
- Stray returns: valid bits seen in IDLE, WR, RD_LOCAL or RESP are ignored and stray_cnt increments by 1 per cycle. A late valid after a timeout therefore counts as stray.
- Counters are 32-bit and saturate at 32'hFFFFFFFF.
- jtag_readdatavalid is never asserted twice for one read.

Test Plan:
- Read addr={sel=0,...,4'd1}; slave 0 returns 32'h0000_0042 with valid 2 cycles after status_read -> jtag_readdatavalid at accept+4, data 32'h42, read_cnt=1.
- Read with no slave answering, TIMEOUT=64 -> exactly one response at accept+65, data 32'hDEADBEEF, timeout_cnt=1. A valid injected at accept+70 -> stray_cnt=1, no second response.
- Slaves 2 and 5 answer the same cycle with 32'h2 and 32'h5 -> data 32'h2, multi_cnt=1.
- Write sel=3, data 32'hCAFE -> one-cycle status_write with matching addr/data, waitrequest high for 1 cycle, no readdatavalid. Then write LOCAL_SEL offset F -> all counters read back 0 via local reads at accept+2.
- Simultaneous jtag_read and jtag_write held -> read serviced first, write pulse follows after RESP.
- Assert rst during RD_WAIT, then return slave valid -> no jtag_readdatavalid, waitrequest=1 during reset, stray_cnt=1 after reset deasserts.
